// File: rtl/imem_uart_loader_pkg.sv
// imem_uart_loader_pkg: shared widths, halt marker and FSM encoding for the UART program loader.
package imem_uart_loader_pkg;
    localparam int NB_WIDTH       = 32;
    localparam int NB_BYTE        = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [NB_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/imem_uart_loader_if.sv
// imem_uart_loader_if: UART byte input plus instruction-memory write port seen by the loader.
interface imem_uart_loader_if
    import imem_uart_loader_pkg::*;
#(
    parameter int NB_ADDR = 9
);
    logic [NB_BYTE-1:0]  rx_data;
    logic                rx_valid;
    logic                we;
    logic [NB_ADDR-1:0]  addr;
    logic [NB_WIDTH-1:0] data;

    modport master (input rx_data, rx_valid, output we, addr, data);
    modport slave  (output rx_data, rx_valid, input we, addr, data);
endinterface

// File: rtl/imem_uart_loader_byte_word_packer.sv
// imem_uart_loader_byte_word_packer: shifts bytes MSB-first into a word and pulses when 4 have arrived.
module imem_uart_loader_byte_word_packer
    import imem_uart_loader_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_en,
    input  logic                i_valid,
    input  logic [NB_BYTE-1:0]  i_byte,
    output logic                o_word_valid,
    output logic [NB_WIDTH-1:0] o_word
);
    logic [1:0]          r_cnt;
    logic [NB_WIDTH-1:0] r_buf;
    logic                r_word_valid;

    // The buffer already holds the finished word while o_word_valid is high,
    // so a byte arriving in that same cycle can overwrite it safely.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt        <= '0;
            r_buf        <= '0;
            r_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_cnt        <= '0;
            r_buf        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= i_en && i_valid && r_cnt == 2'd3;
            if (i_en && i_valid) begin
                r_buf <= {r_buf[NB_WIDTH-NB_BYTE-1:0], i_byte};
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    assign o_word_valid = r_word_valid;
    assign o_word       = r_buf;
endmodule

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: packs UART bytes into big-endian words and writes them to instruction memory
// from address 0 until the halt word arrives or the memory is full.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int NB_ADDR = 9
)(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    imem_uart_loader_if.master   bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [NB_ADDR-2:0]   o_word_count
);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(2**NB_ADDR - BYTES_PER_WORD);

    state_t              r_state, w_next;
    logic [NB_ADDR-1:0]  r_ptr, r_addr;
    logic [NB_ADDR-2:0]  r_count;
    logic [NB_WIDTH-1:0] r_data, w_word;
    logic                r_we, r_overflow, w_word_valid, w_arm, w_load, w_last;

    assign w_load = r_state == LOAD;
    assign w_arm  = i_start && !w_load;
    // Decided from the write registered last cycle, so DONE follows o_we by one cycle.
    assign w_last = r_we && (r_data == HALT_WORD || r_addr == LAST_ADDR);

    imem_uart_loader_byte_word_packer u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_arm),
        .i_en         (w_load),
        .i_valid      (bus.rx_valid),
        .i_byte       (bus.rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = w_arm ? LOAD : (w_load && w_last) ? DONE : r_state;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_we       <= 1'b0;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_we <= w_load && w_word_valid;
            if (w_arm) begin
                r_ptr      <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (w_load && w_word_valid) begin
                r_addr  <= r_ptr;
                r_data  <= w_word;
                r_ptr   <= r_ptr + NB_ADDR'(BYTES_PER_WORD);
                r_count <= r_count + 1'b1;
            end else if (w_load && r_we && r_addr == LAST_ADDR && r_data != HALT_WORD) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.we       = r_we;
    assign bus.addr     = r_addr;
    assign bus.data     = r_data;
    assign o_busy       = w_load;
    assign o_done       = r_state == DONE;
    assign o_overflow   = r_overflow;
    assign o_word_count = r_count;
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: drives a 512-byte and a 16-byte loader with the same byte stream and
// checks both every cycle against a word-level model, plus literal checks of the directed cases.
module tb_imem_uart_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       rx_valid;
    logic [7:0] rx_data;

    logic       busy0, done0, ovf0, busy1, done1, ovf1;
    logic [7:0] wc0;
    logic [2:0] wc1;

    int vectors = 0;
    int miscompares = 0;

    imem_uart_loader_if #(.NB_ADDR(9)) bus0 ();
    imem_uart_loader_if #(.NB_ADDR(4)) bus1 ();
    assign bus0.rx_data  = rx_data;
    assign bus0.rx_valid = rx_valid;
    assign bus1.rx_data  = rx_data;
    assign bus1.rx_valid = rx_valid;

    imem_uart_loader #(.NB_ADDR(9)) dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .bus(bus0),
        .o_busy(busy0), .o_done(done0), .o_overflow(ovf0), .o_word_count(wc0)
    );
    imem_uart_loader #(.NB_ADDR(4)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .bus(bus1),
        .o_busy(busy1), .o_done(done1), .o_overflow(ovf1), .o_word_count(wc1)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 loading, 2 finished; one index per DUT.
    int          mode[2], nb[2], ptr[2], wc[2], eaddr[2];
    bit          ovf[2], pend[2], ewe[2];
    logic [31:0] acc[2], pword[2], edata[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  nwords;
            int  nm;
            bit  nwe;
            nwords = (k == 0) ? 128 : 4;
            nm  = mode[k];
            nwe = 1'b0;
            if (!rst_n) begin
                nm = 0; nb[k] = 0; ptr[k] = 0; wc[k] = 0; eaddr[k] = 0;
                ovf[k] = 0; pend[k] = 0; acc[k] = 0; pword[k] = 0; edata[k] = 0;
            end else if (mode[k] != 1) begin
                if (start) begin
                    nm = 1; nb[k] = 0; ptr[k] = 0; wc[k] = 0; ovf[k] = 0; pend[k] = 0; acc[k] = 0;
                end
            end else begin
                if (ewe[k]) begin
                    if (edata[k] == 32'hFFFF_FFFF) nm = 2;
                    else if (eaddr[k] == nwords * 4 - 4) begin
                        nm = 2;
                        ovf[k] = 1;
                    end
                end
                if (pend[k]) begin
                    nwe = 1'b1;
                    eaddr[k] = ptr[k] * 4;
                    edata[k] = pword[k];
                    ptr[k]++;
                    wc[k]++;
                    pend[k] = 0;
                end
                if (rx_valid) begin
                    acc[k] = (acc[k] << 8) | 32'(rx_data);
                    nb[k]++;
                    if (nb[k] == 4) begin
                        pword[k] = acc[k];
                        pend[k]  = 1;
                        nb[k]    = 0;
                    end
                end
            end
            ewe[k]  = nwe;
            mode[k] = nm;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
        end
    endtask

    int la0[$], la1[$];
    logic [31:0] ld0[$], ld1[$];

    // Per-cycle compare, well clear of both clock edges.
    always @(posedge clk) begin
        #3;
        chk("we0", bus0.we, ewe[0]);
        chk("addr0", bus0.addr, eaddr[0]);
        chk("data0", bus0.data, edata[0]);
        chk("busy0", busy0, mode[0] == 1);
        chk("done0", done0, mode[0] == 2);
        chk("ovf0", ovf0, ovf[0]);
        chk("wc0", wc0, wc[0]);
        chk("we1", bus1.we, ewe[1]);
        chk("addr1", bus1.addr, eaddr[1]);
        chk("data1", bus1.data, edata[1]);
        chk("busy1", busy1, mode[1] == 1);
        chk("done1", done1, mode[1] == 2);
        chk("ovf1", ovf1, ovf[1]);
        chk("wc1", wc1, wc[1]);
        if (bus0.we) begin la0.push_back(int'(bus0.addr)); ld0.push_back(bus0.data); end
        if (bus1.we) begin la1.push_back(int'(bus1.addr)); ld1.push_back(bus1.data); end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        la0.delete(); ld0.delete(); la1.delete(); ld1.delete();
    endtask

    logic [7:0] basic[12] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        start    = 1'b0;
        rst_n    = 1'b0;
        idle(3);
        chk("rst_we", bus0.we, 1'b0);
        chk("rst_addr", bus0.addr, 0);
        chk("rst_data", bus0.data, 0);
        chk("rst_flags", {busy0, done0, ovf0}, 3'b000);
        chk("rst_wc", wc0, 0);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        idle(2);
        chk("idle_nwrites", la0.size(), 0);
        chk("idle_busy", busy0, 1'b0);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h2A);
        idle(2);
        chk("idle_nwrites2", la0.size(), 1);
        if (la0.size() == 1) begin
            chk("idle_addr", la0[0], 0);
            chk("idle_data", ld0[0], 32'h0000_002A);
        end

        do_reset();
        clear_logs();
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(basic[i]);
        idle(3);
        chk("basic_nwrites", la0.size(), 3);
        if (la0.size() == 3) begin
            chk("basic_a0", la0[0], 0);
            chk("basic_d0", ld0[0], 32'h1234_5678);
            chk("basic_a1", la0[1], 4);
            chk("basic_d1", ld0[1], 32'hABCD_EF01);
            chk("basic_a2", la0[2], 8);
            chk("basic_d2", ld0[2], 32'hFFFF_FFFF);
        end
        chk("basic_status", {done0, ovf0, wc0}, {1'b1, 1'b0, 8'd3});

        pulse_start();
        chk("restart_status", {busy0, done0, ovf0, wc0}, {1'b1, 1'b0, 1'b0, 8'd0});
        clear_logs();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(2);
        chk("restart_nwrites", la0.size(), 1);
        if (la0.size() == 1) chk("restart_write", {la0[0], ld0[0]}, {32'd0, 32'hAABB_CCDD});

        do_reset();
        clear_logs();
        pulse_start();
        send_byte(8'h5A); send_byte(8'hA5);
        do_reset();
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle(2);
        chk("midrst_nwrites", la0.size(), 1);
        if (la0.size() == 1) chk("midrst_write", {la0[0], ld0[0]}, {32'd0, 32'h1122_3344});

        do_reset();
        clear_logs();
        pulse_start();
        for (int i = 0; i < 17; i++) send_byte(8'(i * 13 + 1));
        idle(3);
        chk("ovf_nwrites", la1.size(), 4);
        if (la1.size() == 4) begin
            chk("ovf_a0", la1[0], 0);
            chk("ovf_a3", la1[3], 12);
            chk("ovf_d0", ld1[0], 32'h010E_1B28);
        end
        chk("ovf_status", {ovf1, done1, busy1, wc1}, {1'b1, 1'b1, 1'b0, 3'd4});
        chk("ovf_big_status", {busy0, wc0}, {1'b1, 8'd4});
        pulse_start();
        chk("ovf_restart", {busy1, done1, ovf1, wc1}, {1'b1, 1'b0, 1'b0, 3'd0});

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n    = $urandom_range(0, 499) != 0;
            start    = $urandom_range(0, 29) == 0;
            rx_valid = $urandom_range(0, 9) < 6;
            rx_data  = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1; start = 1'b0; rx_valid = 1'b0;
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
